// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and the loader FSM state type.
package imem_pkg;

  localparam int unsigned IMEM_BYTES  = 8192;
  localparam int unsigned IMEM_ADDR_W = $clog2(IMEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake (in) and instruction-memory write port (out) of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = imem_pkg::IMEM_ADDR_W
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  // master: the loader side; slave: byte source plus memory write port
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, we, waddr, wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer: lane counter plus 4x8 lane register.
module imem_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        strobe_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clr_i) begin
      lane_d = '0;
      word_d = '0;
    end else if (strobe_i) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_i;
      lane_d = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = strobe_i & ~clr_i & (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into words and writes them sequentially.
// Optional running word checksum enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = IMEM_BYTES,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-2:0] len_words_i,
  imem_loader_if.master     bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       cksum_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-2:0] rem_q, rem_d;
  logic              err_q, err_d;
  logic              start_acc;
  logic              strobe;
  logic              word_full;
  logic [31:0]       word;

  assign start_acc = (state_q == IDLE) & start_i;

  imem_word_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (start_acc),
    .strobe_i    (strobe),
    .byte_i      (bus.byte_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    strobe  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          addr_d  = {base_addr_i[ADDR_W-1:2], 2'b00};
          rem_d   = len_words_i;
          err_d   = 1'b0;
          state_d = (len_words_i == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        strobe = bus.byte_valid;
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        rem_d = rem_q - (ADDR_W-1)'(1);
        // Last-word check takes priority: a final word at the top address is not an overflow.
        if (rem_q == (ADDR_W-1)'(1)) begin
          state_d = DONE;
        end else if (addr_q == LAST_ADDR) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(4);
          state_d = COLLECT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready = (state_q == COLLECT);
  assign bus.we         = (state_q == WRITE);
  assign bus.waddr      = addr_q;
  assign bus.wdata      = word;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign err_o          = err_q;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (start_acc) cksum_d = '0;
    else if (state_q == WRITE) cksum_d = cksum_q + word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end

  assign cksum_o = cksum_q;
`else
  assign cksum_o = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven and randomized loads against a word-level model.
module tb_imem_loader;

  localparam int unsigned MEMB = 8192;
  localparam int unsigned AW   = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-2:0] len;
  logic          busy, done, err;
  logic [31:0]   cksum;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.MEM_BYTES(MEMB), .ADDR_W(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_words_i (len),
    .bus         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .cksum_o     (cksum)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Observed memory writes and done pulses
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            done_cnt = 0;
  logic [7:0]    src[$];

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wa_q.push_back(bus.waddr);
      wd_q.push_back(bus.wdata);
      chk("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_obs();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  task automatic fill_src(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  task automatic run_load(input logic [AW-1:0] b, input int l, input int nbytes,
                          input int gap, input int restart_cyc,
                          output int acc, output bit tout);
    int idx;
    int cyc;
    bit a;
    idx  = 0;
    cyc  = 0;
    tout = 1'b0;
    @(negedge clk);
    start = 1'b1; base = b; len = (AW-1)'(l);
    @(negedge clk);
    start = 1'b0;
    while (1) begin
      if (done === 1'b1) break;
      if (cyc >= 400) begin tout = 1'b1; break; end
      start = (cyc == restart_cyc);
      if (start) begin base = b ^ 13'h1000; len = (AW-1)'(1); end
      bus.byte_valid = (idx < nbytes) && ($urandom_range(99) >= gap);
      bus.byte_data  = (idx < nbytes) ? src[idx] : 8'($urandom);
      a = bus.byte_valid && bus.byte_ready;
      @(negedge clk);
      if (a) idx++;
      cyc++;
    end
    start = 1'b0;
    bus.byte_valid = 1'b0;
    acc = idx;
    @(negedge clk);
  endtask

  // Reference: words land at consecutive aligned addresses, packed LE from the byte stream
  task automatic verify(input string tag, input logic [AW-1:0] b, input int exp_n,
                        input bit exp_err, input int acc, input bit tout);
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic [31:0]   sum;
    int            n;
    sum = '0;
    chk({tag, "_timeout"}, 32'(tout), 32'd0);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(exp_n));
    chk({tag, "_accepted"}, 32'(acc), 32'(4 * exp_n));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    n = (wa_q.size() < exp_n) ? wa_q.size() : exp_n;
    for (int k = 0; k < n; k++) begin
      ea = AW'((int'(b) / 4) * 4 + 4 * k);
      ed = {src[4*k+3], src[4*k+2], src[4*k+1], src[4*k]};
      chk($sformatf("%s_waddr%0d", tag, k), 32'(wa_q[k]), 32'(ea));
      chk($sformatf("%s_wdata%0d", tag, k), wd_q[k], ed);
      sum = sum + ed;
    end
`ifdef IMEM_LOADER_CKSUM_EN
    chk({tag, "_cksum"}, cksum, sum);
`else
    chk({tag, "_cksum"}, cksum, 32'd0);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_we"},    32'(bus.we), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    chk({tag, "_wdata"}, bus.wdata, 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
    chk({tag, "_cksum"}, cksum, 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            nbytes;
    int            gap;
    int            restart;
    int            exp_n;
    bit            exp_err;
    logic [AW-1:0] exp_addr0;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t          vecs[7];
    int            acc;
    bit            tout;
    logic [AW-1:0] rb;
    int            rl;
    int            cap;
    int            nw;

    vecs[0] = '{13'h0000, 2, 8,  0,  -1, 2, 1'b0, 13'h0000};
    vecs[1] = '{13'h0102, 1, 4,  50, -1, 1, 1'b0, 13'h0100};
    vecs[2] = '{13'h1FFC, 3, 12, 0,  -1, 1, 1'b1, 13'h1FFC};
    vecs[3] = '{13'h1FF0, 4, 16, 20, -1, 4, 1'b0, 13'h1FF0};
    vecs[4] = '{13'h0403, 5, 20, 30, -1, 5, 1'b0, 13'h0400};
    vecs[5] = '{13'h0080, 3, 12, 10, 5,  3, 1'b0, 13'h0080};
    vecs[6] = '{13'h1FF8, 3, 12, 0,  -1, 2, 1'b1, 13'h1FF8};

    rst = 1'b1; start = 1'b0; base = '0; len = '0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    for (int v = 0; v < 7; v++) begin
      clear_obs();
      if (v == 0) begin
        src.delete();
        src = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h00, 8'h00};
      end else begin
        fill_src(vecs[v].nbytes);
      end
      run_load(vecs[v].base, vecs[v].len, vecs[v].nbytes, vecs[v].gap, vecs[v].restart, acc, tout);
      verify($sformatf("vec%0d", v), vecs[v].base, vecs[v].exp_n, vecs[v].exp_err, acc, tout);
      if (wa_q.size() > 0) chk($sformatf("vec%0d_addr0", v), 32'(wa_q[0]), 32'(vecs[v].exp_addr0));
`ifdef IMEM_LOADER_CKSUM_EN
      if (v == 0) chk("basic_cksum_const", cksum, 32'h0000_12CA);
`endif
    end

    // Reset after two bytes of a word: no write, state cleared, next load unaffected
    clear_obs();
    @(negedge clk);
    start = 1'b1; base = 13'h0200; len = (AW-1)'(1);
    @(negedge clk);
    start = 1'b0; bus.byte_valid = 1'b1; bus.byte_data = 8'hAA;
    @(negedge clk);
    bus.byte_data = 8'hBB;
    @(negedge clk);
    bus.byte_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    chk("midrst_no_write", 32'(wa_q.size()), 32'd0);
    clear_obs();
    fill_src(4);
    run_load(13'h0300, 1, 4, 0, -1, acc, tout);
    verify("after_rst", 13'h0300, 1, 1'b0, acc, tout);

    // Zero-length load
    clear_obs();
    @(negedge clk);
    start = 1'b1; base = 13'h0040; len = '0;
    chk("zlen_busy_T", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("zlen_done_T1", 32'(done), 32'd1);
    chk("zlen_busy_T1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("zlen_done_T2", 32'(done), 32'd0);
    chk("zlen_busy_T2", 32'(busy), 32'd0);
    chk("zlen_no_write", 32'(wa_q.size()), 32'd0);

    // Randomized loads, expectations from the address-space model
    for (int r = 0; r < 6; r++) begin
      clear_obs();
      rb  = ($urandom_range(1) == 1) ? AW'(MEMB - 32 + $urandom_range(31)) : AW'($urandom_range(MEMB - 1));
      rl  = $urandom_range(6, 1);
      cap = (int'(MEMB) - (int'(rb) / 4) * 4) / 4;
      nw  = (rl < cap) ? rl : cap;
      fill_src(4 * rl + 4);
      run_load(rb, rl, 4 * rl + 4, $urandom_range(60), -1, acc, tout);
      verify($sformatf("rnd%0d", r), rb, nw, (rl > cap), acc, tout);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
